// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths and constants for the integer square-root finder
package sqrt_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int RW_DEF    = WIDTH_DEF / 2;
    localparam int SQW_DEF   = WIDTH_DEF + 1;
    localparam int DW_DEF    = RW_DEF + 2;

    localparam int SQ_INIT  = 1;
    localparam int DEL_INIT = 3;
    localparam int DEL_STEP = 2;

endpackage

// File: rtl/sqrt_datapath.sv
// rtl/sqrt_datapath.sv - odd-number accumulation datapath for floor(sqrt(a))
// sq_q tracks (k+1)^2 and del_q tracks 2k+3 after k steps; the controller stops stepping once greater rises.
module sqrt_datapath
    import sqrt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [WIDTH-1:0]     a_in,
    input  logic                 en_a,
    input  logic                 en_del,
    input  logic                 en_sq,
    input  logic                 ld_add,
    input  logic                 en_out,
    output logic                 greater,
    output logic [WIDTH/2-1:0]   root,
    output logic                 root_vld,
    output logic                 ovf
);

    localparam int RW  = WIDTH / 2;
    localparam int SQW = WIDTH + 1;
    localparam int DW  = RW + 2;
    localparam int CW  = RW + 1;

    localparam logic [CW-1:0] CNT_MAX = {1'b1, {RW{1'b0}}};

    logic [WIDTH-1:0] a_q, a_d;
    logic [SQW-1:0]   sq_q, sq_d;
    logic [DW-1:0]    del_q, del_d;
    logic [CW-1:0]    step_cnt_q, step_cnt_d;
    logic [RW-1:0]    root_q, root_d;
    logic             root_vld_q, root_vld_d;
    logic             ovf_q, ovf_d;

    logic             any_load;
    logic [CW-1:0]    cnt_base;
    logic             sat_hit;
    logic             do_step;

    always_comb begin
        any_load = en_a | en_del | en_sq;
        // A load restarts the step count, so a step in the same cycle counts as the first one.
        cnt_base = any_load ? '0 : step_cnt_q;
        sat_hit  = ld_add && (cnt_base == CNT_MAX);
        do_step  = ld_add && !sat_hit;

        a_d = en_a ? a_in : a_q;

        if (en_sq) begin
            sq_d = SQW'(SQ_INIT);
        end else if (do_step) begin
            sq_d = sq_q + SQW'(del_q);
        end else begin
            sq_d = sq_q;
        end

        if (en_del) begin
            del_d = DW'(DEL_INIT);
        end else if (do_step) begin
            del_d = del_q + DW'(DEL_STEP);
        end else begin
            del_d = del_q;
        end

        step_cnt_d = do_step ? cnt_base + CW'(1) : cnt_base;
        ovf_d      = any_load ? 1'b0 : (ovf_q | sat_hit);

        // del = 2k+3, so del>>1 = k+1 and the root is one less; uses the pre-step del.
        root_d     = en_out ? (del_q[RW:1] - RW'(1)) : root_q;
        root_vld_d = en_out ? 1'b1 : (any_load ? 1'b0 : root_vld_q);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q        <= '0;
            sq_q       <= SQW'(SQ_INIT);
            del_q      <= DW'(DEL_INIT);
            step_cnt_q <= '0;
            root_q     <= '0;
            root_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            sq_q       <= sq_d;
            del_q      <= del_d;
            step_cnt_q <= step_cnt_d;
            root_q     <= root_d;
            root_vld_q <= root_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign greater  = sq_q > {1'b0, a_q};
    assign root     = root_q;
    assign root_vld = root_vld_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_sqrt_datapath.sv
// tb/tb_sqrt_datapath.sv - randomized and directed checks of sqrt_datapath against a behavioural model
module tb_sqrt_datapath;

    localparam int WIDTH = 8;
    localparam int RW    = WIDTH / 2;

    logic             clk = 1'b0;
    logic             clr_n;
    logic [WIDTH-1:0] a_in;
    logic             en_a, en_del, en_sq, ld_add, en_out;
    logic             greater;
    logic [RW-1:0]    root;
    logic             root_vld;
    logic             ovf;

    int vectors   = 0;
    int miscompares = 0;

    int a_m, sq_m, del_m, cnt_m, root_m, vld_m, ovf_m;

    always #5 clk = ~clk;

    sqrt_datapath #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .a_in     (a_in),
        .en_a     (en_a),
        .en_del   (en_del),
        .en_sq    (en_sq),
        .ld_add   (ld_add),
        .en_out   (en_out),
        .greater  (greater),
        .root     (root),
        .root_vld (root_vld),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int isqrt(input int a);
        int r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    task automatic model_reset();
        a_m = 0; sq_m = 1; del_m = 3; cnt_m = 0;
        root_m = 0; vld_m = 0; ovf_m = 0;
    endtask

    // Applies the register-transfer rules to the model for one rising edge.
    task automatic model_edge();
        bit load, step, sat;
        int cnt0;
        load = en_a | en_del | en_sq;
        cnt0 = load ? 0 : cnt_m;
        sat  = ld_add && (cnt0 == (1 << RW));
        step = ld_add && !sat;
        if (en_out) begin
            root_m = ((del_m / 2) - 1) % (1 << RW);
            if (root_m < 0) root_m += (1 << RW);
            vld_m  = 1;
        end else if (load) begin
            vld_m = 0;
        end
        ovf_m = load ? 0 : (ovf_m | int'(sat));
        if (en_a) a_m = int'(a_in);
        if (en_sq)     sq_m  = 1;
        else if (step) sq_m  = (sq_m + del_m) % (1 << (WIDTH + 1));
        if (en_del)    del_m = 3;
        else if (step) del_m = (del_m + 2) % (1 << (RW + 2));
        cnt_m = step ? cnt0 + 1 : cnt0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".greater"}, 32'(greater), 32'(sq_m > a_m));
        chk({tag, ".root"},    32'(root),    32'(root_m));
        chk({tag, ".vld"},     32'(root_vld), 32'(vld_m));
        chk({tag, ".ovf"},     32'(ovf),     32'(ovf_m));
    endtask

    task automatic cyc(input logic ea, input logic ed, input logic es,
                       input logic la, input logic eo, input logic [WIDTH-1:0] a);
        @(negedge clk);
        en_a = ea; en_del = ed; en_sq = es; ld_add = la; en_out = eo; a_in = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all("model");
    endtask

    task automatic load(input logic [WIDTH-1:0] a);
        cyc(1, 1, 1, 0, 0, a);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, '0);
    endtask

    task automatic out_cap();
        cyc(0, 0, 0, 0, 1, '0);
    endtask

    initial begin
        clr_n = 1'b0;
        {en_a, en_del, en_sq, ld_add, en_out} = '0;
        a_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // Asynchronous reset in the middle of an iteration.
        load(8'd200);
        steps(5);
        out_cap();
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk("rst.greater", 32'(greater), 32'd1);
        chk("rst.root",    32'(root),    32'd0);
        chk("rst.vld",     32'(root_vld), 32'd0);
        chk("rst.ovf",     32'(ovf),     32'd0);
        @(negedge clk);
        {en_a, en_del, en_sq, ld_add, en_out} = '0;
        clr_n = 1'b1;

        load(8'd0);
        chk("a0.greater", 32'(greater), 32'd1);
        out_cap();
        chk("a0.root", 32'(root), 32'd0);
        chk("a0.vld",  32'(root_vld), 32'd1);

        load(8'd8);
        steps(1);
        chk("a8.greater1", 32'(greater), 32'd0);
        steps(1);
        chk("a8.greater2", 32'(greater), 32'd1);
        out_cap();
        chk("a8.root", 32'(root), 32'd2);

        load(8'd255);
        chk("a255.vld_clr", 32'(root_vld), 32'd0);
        steps(14);
        chk("a255.greater14", 32'(greater), 32'd0);
        steps(1);
        chk("a255.greater15", 32'(greater), 32'd1);
        out_cap();
        chk("a255.root", 32'(root), 32'd15);

        load(8'd224);
        steps(13);
        chk("a224.greater13", 32'(greater), 32'd0);
        steps(1);
        chk("a224.greater14", 32'(greater), 32'd1);
        out_cap();
        chk("a224.root", 32'(root), 32'd14);

        load(8'd255);
        steps(16);
        chk("ovf.after16", 32'(ovf), 32'd0);
        steps(1);
        chk("ovf.after17", 32'(ovf), 32'd1);
        steps(2);
        out_cap();
        chk("ovf.frozen_root", 32'(root), 32'd0);
        chk("ovf.sticky", 32'(ovf), 32'd1);
        load(8'd5);
        chk("ovf.cleared", 32'(ovf), 32'd0);

        load(8'd3);
        steps(2);
        chk("prio.greater_pre", 32'(greater), 32'd1);
        cyc(0, 0, 1, 1, 0, '0);
        chk("prio.sq_loaded", 32'(greater), 32'd0);
        out_cap();
        chk("prio.del_stepped", 32'(root), 32'd3);

        load(8'd100);
        steps(3);
        cyc(0, 0, 0, 1, 1, '0);
        chk("outstep.pre", 32'(root), 32'd3);
        out_cap();
        chk("outstep.post", 32'(root), 32'd4);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)      cyc(1, 1, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
            else if (r < 18) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            else if (r < 30) cyc(0, 0, 0, $urandom_range(0, 1) == 1, 1, '0);
            else             cyc(0, 0, 0, 1, 0, '0);
        end

        // Closed loop with a minimal controller: every operand in range.
        for (int a = 0; a < (1 << WIDTH); a++) begin
            int n;
            load(8'(a));
            n = 0;
            while (!greater && n < 20) begin
                steps(1);
                n++;
            end
            chk("loop.bound", 32'(n < 20), 32'd1);
            out_cap();
            chk("loop.root", 32'(root), 32'(isqrt(a)));
            chk("loop.ovf",  32'(ovf),  32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
